// File: rtl/mips_decode_pipe.sv
// Elastic pipelined MIPS instruction decoder: R/I/J classification, field split,
// immediate extension, and saturating per-format retire counters.

package mips;
  typedef struct packed {
    logic [5:0] opcode;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt;
    logic [5:0] funct;
  } rtype_t;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [15:0] imm;
  } itype_t;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [25:0] target;
  } jtype_t;

  typedef union packed {
    rtype_t r;
    itype_t i;
    jtype_t j;
  } mipsinst;
endpackage

module mips_decode_pipe
  import mips::*;
#(
  parameter int DATA_W = 32,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              cnt_clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  mipsinst           inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        fmt,
  output logic [5:0]        opcode,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [4:0]        shamt,
  output logic [5:0]        funct,
  output logic [DATA_W-1:0] imm_ext,
  output logic [25:0]       jtarget,
  output logic [CNT_W-1:0]  r_cnt,
  output logic [CNT_W-1:0]  i_cnt,
  output logic [CNT_W-1:0]  j_cnt
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both
  // high. A producer holding valid keeps its data stable until ready; ready never
  // depends on valid of the same interface.

  localparam logic [1:0] FMT_R = 2'd0;
  localparam logic [1:0] FMT_I = 2'd1;
  localparam logic [1:0] FMT_J = 2'd2;

  typedef struct packed {
    logic [1:0]        fmt;
    logic [5:0]        opcode;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [4:0]        shamt;
    logic [5:0]        funct;
    logic [DATA_W-1:0] imm_ext;
    logic [25:0]       jtarget;
  } dec_t;

  dec_t              dec_d;
  dec_t              pipe_q [STAGES];
  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] ld;
  logic [STAGES-1:0] mv;
  logic [DATA_W-1:0] imm_x;
  logic              retire;

  generate
    if (DATA_W == 16) begin : g_imm16
      assign imm_x = inst.i.imm;
    end else begin : g_immx
      logic zext;
      // Logical immediates (andi/ori/xori) are unsigned; everything else sign-extends.
      assign zext  = inst.i.opcode inside {6'h0C, 6'h0D, 6'h0E};
      assign imm_x = zext ? {{(DATA_W-16){1'b0}}, inst.i.imm}
                          : {{(DATA_W-16){inst.i.imm[15]}}, inst.i.imm};
    end
  endgenerate

  always_comb begin
    dec_d         = '0;
    dec_d.opcode  = inst.r.opcode;
    dec_d.rs      = inst.r.rs;
    dec_d.rt      = inst.r.rt;
    dec_d.rd      = inst.r.rd;
    dec_d.shamt   = inst.r.shamt;
    dec_d.funct   = inst.r.funct;
    dec_d.imm_ext = imm_x;
    dec_d.jtarget = inst.j.target;
    case (inst.r.opcode)
      6'h00:        dec_d.fmt = FMT_R;
      6'h02, 6'h03: dec_d.fmt = FMT_J;
      default:      dec_d.fmt = FMT_I;
    endcase
  end

  // Ready ripples from the output back toward stage 0 so a freed slot is usable
  // in the same cycle (no bubbles).
  always_comb begin
    mv = '0;
    ld = '0;
    mv[STAGES-1] = v_q[STAGES-1] && out_ready;
    ld[STAGES-1] = !v_q[STAGES-1] || mv[STAGES-1];
    for (int k = STAGES - 2; k >= 0; k--) begin
      mv[k] = v_q[k] && ld[k+1];
      ld[k] = !v_q[k] || mv[k];
    end
  end

  assign in_ready = ld[0] && !flush;
  assign retire   = v_q[STAGES-1] && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      for (int k = 0; k < STAGES; k++) pipe_q[k] <= '0;
    end else begin
      if (flush) begin
        v_q <= '0;
      end else begin
        if (ld[0]) begin
          v_q[0] <= in_valid;
          if (in_valid) pipe_q[0] <= dec_d;
        end
        for (int k = 1; k < STAGES; k++) begin
          if (ld[k]) begin
            v_q[k] <= v_q[k-1];
            if (v_q[k-1]) pipe_q[k] <= pipe_q[k-1];
          end
        end
      end
    end
  end

  // Clear beats a coincident retire; a retire in a flush cycle still counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      i_cnt <= '0;
      j_cnt <= '0;
    end else if (cnt_clr) begin
      r_cnt <= '0;
      i_cnt <= '0;
      j_cnt <= '0;
    end else if (retire) begin
      case (pipe_q[STAGES-1].fmt)
        FMT_R:   if (r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
        FMT_I:   if (i_cnt != '1) i_cnt <= i_cnt + CNT_W'(1);
        FMT_J:   if (j_cnt != '1) j_cnt <= j_cnt + CNT_W'(1);
        default: ;
      endcase
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign fmt       = pipe_q[STAGES-1].fmt;
  assign opcode    = pipe_q[STAGES-1].opcode;
  assign rs        = pipe_q[STAGES-1].rs;
  assign rt        = pipe_q[STAGES-1].rt;
  assign rd        = pipe_q[STAGES-1].rd;
  assign shamt     = pipe_q[STAGES-1].shamt;
  assign funct     = pipe_q[STAGES-1].funct;
  assign imm_ext   = pipe_q[STAGES-1].imm_ext;
  assign jtarget   = pipe_q[STAGES-1].jtarget;

endmodule

// File: tb/tb_mips_decode_pipe.sv
// Directed bench for mips_decode_pipe: queued expected records checked by an
// independent output monitor, plus directed checks of counters, flush and reset.

module tb_mips_decode_pipe;
  localparam int DATA_W = 32;
  localparam int STAGES = 2;
  localparam int CNT_W  = 4;

  logic              clk;
  logic              rst_n;
  logic              flush;
  logic              cnt_clr;
  logic              in_valid;
  logic              in_ready;
  mips::mipsinst     inst;
  logic              out_valid;
  logic              out_ready;
  logic [1:0]        fmt;
  logic [5:0]        opcode;
  logic [4:0]        rs, rt, rd, shamt;
  logic [5:0]        funct;
  logic [DATA_W-1:0] imm_ext;
  logic [25:0]       jtarget;
  logic [CNT_W-1:0]  r_cnt, i_cnt, j_cnt;

  mips_decode_pipe #(.DATA_W(DATA_W), .STAGES(STAGES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .cnt_clr(cnt_clr),
    .in_valid(in_valid), .in_ready(in_ready), .inst(inst),
    .out_valid(out_valid), .out_ready(out_ready),
    .fmt(fmt), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
    .funct(funct), .imm_ext(imm_ext), .jtarget(jtarget),
    .r_cnt(r_cnt), .i_cnt(i_cnt), .j_cnt(j_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [65:0] exp_q[$];   // {fmt, word, imm_ext}
  int          lat_q[$];
  bit          lat_chk = 1'b0;
  int          n_chk = 0;
  int          n_err = 0;
  int          acc_n = 0;
  logic [65:0] mon_e;
  int          mon_a;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_output: got fmt=%0d opcode=0x%0h expected none", fmt, opcode);
      end else begin
        mon_e = exp_q.pop_front();
        mon_a = lat_q.pop_front();
        chk("fmt", 64'(fmt), 64'(mon_e[65:64]));
        chk("fields", 64'({opcode, rs, rt, rd, shamt, funct}), 64'(mon_e[63:32]));
        chk("jtarget", 64'(jtarget), 64'(mon_e[57:32]));
        chk("imm_ext", 64'(imm_ext), 64'(mon_e[31:0]));
        if (lat_chk) chk("latency", 64'(cyc - mon_a), 64'(STAGES - 1));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [31:0] w, input logic [1:0] f, input logic [31:0] im);
    int t;
    in_valid = 1'b1;
    inst     = w;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!in_ready && t < 200);
    if (!in_ready) begin
      n_chk++;
      n_err++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 for word 0x%08h", w);
      in_valid = 1'b0;
      return;
    end
    exp_q.push_back({f, w, im});
    lat_q.push_back(cyc + 1);
    acc_n++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic clr_cnt();
    cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    chk("clr_r", 64'(r_cnt), 64'd0);
    chk("clr_i", 64'(i_cnt), 64'd0);
    chk("clr_j", 64'(j_cnt), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    cnt_clr   = 1'b0;
    in_valid  = 1'b0;
    inst      = '0;
    out_ready = 1'b1;

    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_fmt", 64'(fmt), 64'd0);
    chk("rst_fields", 64'({opcode, rs, rt, rd, shamt, funct, jtarget}), 64'd0);
    chk("rst_imm", 64'(imm_ext), 64'd0);
    chk("rst_cnts", 64'({r_cnt, i_cnt, j_cnt}), 64'd0);
    #10 rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Basic stream with exact latency.
    lat_chk = 1'b1;
    send(32'h012A4020, 2'd0, 32'h00004020);   // add $8,$9,$10
    send(32'h2008FFFF, 2'd1, 32'hFFFFFFFF);   // addi
    send(32'h0C100004, 2'd2, 32'h00000004);   // jal
    drain();
    chk("t1_r_cnt", 64'(r_cnt), 64'd1);
    chk("t1_i_cnt", 64'(i_cnt), 64'd1);
    chk("t1_j_cnt", 64'(j_cnt), 64'd1);
    clr_cnt();

    // Immediate extension, back to back.
    send(32'h3508FFFF, 2'd1, 32'h0000FFFF);   // ori  zero-ext
    send(32'h2108FFFF, 2'd1, 32'hFFFFFFFF);   // addi sign-ext
    send(32'h3108FFFF, 2'd1, 32'h0000FFFF);   // andi zero-ext
    send(32'h3908FFFF, 2'd1, 32'h0000FFFF);   // xori zero-ext
    send(32'h8D090004, 2'd1, 32'h00000004);   // lw
    send(32'h1109FFFE, 2'd1, 32'hFFFFFFFE);   // beq
    send(32'h08000010, 2'd2, 32'h00000010);   // j
    drain();
    chk("t2_i_cnt", 64'(i_cnt), 64'd6);
    chk("t2_j_cnt", 64'(j_cnt), 64'd1);
    chk("t2_r_cnt", 64'(r_cnt), 64'd0);
    lat_chk = 1'b0;
    clr_cnt();

    // Backpressure: only STAGES words enter, output holds.
    out_ready = 1'b0;
    acc_n = 0;
    fork
      begin
        send(32'h012A4020, 2'd0, 32'h00004020);
        send(32'h2008FFFF, 2'd1, 32'hFFFFFFFF);
        send(32'h0C100004, 2'd2, 32'h00000004);
        send(32'h01095022, 2'd0, 32'h00005022);   // sub $10,$8,$9
        send(32'h3508FFFF, 2'd1, 32'h0000FFFF);
      end
      begin
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("bp_accepted", 64'(acc_n), 64'(STAGES));
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        for (int n = 0; n < 3; n++) begin
          chk("bp_out_valid", 64'(out_valid), 64'd1);
          chk("bp_hold_word", 64'({opcode, rs, rt, rd, shamt, funct}), 64'h012A4020);
          chk("bp_hold_imm", 64'(imm_ext), 64'h00004020);
          @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_r_cnt", 64'(r_cnt), 64'd2);
    chk("bp_i_cnt", 64'(i_cnt), 64'd2);
    chk("bp_j_cnt", 64'(j_cnt), 64'd1);
    clr_cnt();

    // Flush with two in flight; the head retires in the flush cycle.
    out_ready = 1'b0;
    send(32'h012A4020, 2'd0, 32'h00004020);
    send(32'h2008FFFF, 2'd1, 32'hFFFFFFFF);
    out_ready = 1'b1;
    flush     = 1'b1;
    @(negedge clk);
    chk("fl_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("fl_out_valid", 64'(out_valid), 64'd0);
    chk("fl_r_cnt", 64'(r_cnt), 64'd1);
    chk("fl_i_cnt", 64'(i_cnt), 64'd0);
    exp_q.delete();
    lat_q.delete();
    send(32'h0C100004, 2'd2, 32'h00000004);
    drain();
    chk("fl_j_cnt", 64'(j_cnt), 64'd1);
    clr_cnt();

    // Counter saturation and clear-beats-retire.
    for (int n = 0; n < 20; n++) send(32'h012A4020, 2'd0, 32'h00004020);
    drain();
    chk("sat_r_cnt", 64'(r_cnt), 64'd15);
    out_ready = 1'b0;
    send(32'h012A4020, 2'd0, 32'h00004020);
    @(posedge clk);
    #1;
    chk("cc_out_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    cnt_clr   = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    chk("cc_r_cnt", 64'(r_cnt), 64'd0);
    chk("cc_out_valid_after", 64'(out_valid), 64'd0);

    // Asynchronous reset mid-stream with nonzero counters.
    send(32'h0C100004, 2'd2, 32'h00000004);
    drain();
    chk("ar_j_before", 64'(j_cnt), 64'd1);
    out_ready = 1'b0;
    send(32'h012A4020, 2'd0, 32'h00004020);
    send(32'h2008FFFF, 2'd1, 32'hFFFFFFFF);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_out_valid", 64'(out_valid), 64'd0);
    chk("ar_cnts", 64'({r_cnt, i_cnt, j_cnt}), 64'd0);
    chk("ar_fmt_imm", 64'({fmt, imm_ext}), 64'd0);
    exp_q.delete();
    lat_q.delete();
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(32'h2108FFFF, 2'd1, 32'hFFFFFFFF);
    drain();
    chk("ar_resume_i", 64'(i_cnt), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
